// File: rtl/layer_sequencer.sv
// ----------------------------------------------------------------------------
// layer_sequencer
//   Runs one CNN inference job by launching each pipeline stage in index
//   order 0..NUM_STAGES-1 over a level start / done-while-idle handshake.
//   A stage is launched with a one-cycle start pulse. It must then drop its
//   done within ACK_TIMEOUT cycles, or the job is aborted with a sticky error.
//   The stage is complete when it raises done again. The block also tracks
//   the ping-pong feature-map bank and measures the job length in cycles.
//
// Ports
//   clk              in   1           rising-edge clock
//   rst_n            in   1           asynchronous reset, active low
//   axisif_in_start  in   1           job request (only honoured while idle)
//   axisif_out_done  out  1           high while idle
//   stg_out_start    out  NUM_STAGES  one-hot start pulse to the current stage
//   stg_in_done      in   NUM_STAGES  per-stage done (high while stage idles)
//   out_stage        out  STAGE_BITS  stage currently owned/running
//   out_bufSel       out  1           bank read by out_stage (writes ~bank)
//   out_err          out  1           sticky: a stage never acknowledged start
//   out_cycles       out  CNT_WIDTH   length of the last completed job
// ----------------------------------------------------------------------------
module layer_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_BITS  = 2,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  axisif_in_start,
    output logic                  axisif_out_done,
    output logic [NUM_STAGES-1:0] stg_out_start,
    input  logic [NUM_STAGES-1:0] stg_in_done,
    output logic [STAGE_BITS-1:0] out_stage,
    output logic                  out_bufSel,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  out_cycles
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_RUN = 3'd3,
        NEXT     = 3'd4
    } state_e;

    localparam int TO_BITS = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [STAGE_BITS-1:0] LAST_STAGE = STAGE_BITS'(NUM_STAGES - 1);
    // The timeout counter is cleared in LAUNCH and tested before increment,
    // so matching ACK_TIMEOUT-1 gives exactly ACK_TIMEOUT cycles in WAIT_ACK.
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(ACK_TIMEOUT - 1);
    localparam logic [NUM_STAGES-1:0] ONE_HOT0 = NUM_STAGES'(1);

    state_e                 state_q, state_d;
    logic [STAGE_BITS-1:0]  stage_q, stage_d;
    logic                   bufsel_q, bufsel_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
    logic [TO_BITS-1:0]     to_q, to_d;

    logic                   cur_done_s;
    logic [CNT_WIDTH-1:0]   cnt_inc_s;
    logic [NUM_STAGES-1:0]  start_s;

    // Only the owned stage's done bit is ever looked at.
    assign cur_done_s = stg_in_done[stage_q];

    // Saturating increment of the job cycle counter.
    assign cnt_inc_s = (&cnt_q) ? cnt_q : (cnt_q + CNT_WIDTH'(1));

    // Start pulse decoded from state/stage registers only (no input path).
    always_comb begin
        start_s = '0;
        if (state_q == LAUNCH) begin
            start_s = ONE_HOT0 << stage_q;
        end else begin
            start_s = '0;
        end
    end

    assign axisif_out_done = (state_q == IDLE);
    assign stg_out_start   = start_s;
    assign out_stage       = stage_q;
    assign out_bufSel      = bufsel_q;
    assign out_err         = err_q;
    assign out_cycles      = cycles_q;

    // Next-state and datapath update for the sequencing FSM.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        bufsel_d = bufsel_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        to_d     = to_q;
        case (state_q)
            IDLE: begin
                if (axisif_in_start) begin
                    stage_d  = '0;
                    bufsel_d = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = LAUNCH;
                end else begin
                    state_d  = IDLE;
                end
            end
            LAUNCH: begin
                to_d    = '0;
                cnt_d   = cnt_inc_s;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                cnt_d = cnt_inc_s;
                // An acknowledge in the last allowed cycle still wins.
                if (!cur_done_s) begin
                    state_d = WAIT_RUN;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d    = to_q + TO_BITS'(1);
                end
            end
            WAIT_RUN: begin
                cnt_d = cnt_inc_s;
                if (cur_done_s) begin
                    state_d = NEXT;
                end else begin
                    state_d = WAIT_RUN;
                end
            end
            NEXT: begin
                cnt_d    = cnt_inc_s;
                bufsel_d = ~bufsel_q;
                if (stage_q == LAST_STAGE) begin
                    // Includes this final NEXT cycle in the published length.
                    cycles_d = cnt_inc_s;
                    state_d  = IDLE;
                end else begin
                    stage_d  = stage_q + STAGE_BITS'(1);
                    state_d  = LAUNCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            bufsel_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            cycles_q <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            bufsel_q <= bufsel_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            to_q     <= to_d;
        end
    end

endmodule
